tf_loader: RTL and testbench
============================

Name: tf_loader

Overview:
- Twiddle-factor table loader; the writer-side counterpart of the twiddle-factor generator's register bank, which only reads that bank.
- Accepts a valid/ready word stream from the host/DMA side: first the modulus, then every base entry (depth-major, bank-minor), then every constant entry.
- Drives one registered write port into the base/constant register bank.
- Signals done, or range-error, so the NTT controller can enable twiddle-factor reads.

Parameters:
- D_WIDTH, 64, data word width.
- IT_DEPTH, 3, iteration depth; the base table has IT_DEPTH+3 depth rows.
- TF_BANK, 15, base banks per depth row.
- TF_CONST_BANK, 15, constant entries.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a load; ignored unless in IDLE, DONE or ERR.
- in_valid  in  1  stream word valid.
- in_data  in  D_WIDTH  stream word.
- in_ready  out  1  loader can accept a word this cycle.
- wr_en  out  1  write strobe to the register bank.
- wr_sel  out  1  0 = base table, 1 = constant table.
- wr_depth  out  3  base depth-row index; 0 when wr_sel=1.
- wr_bank  out  4  bank/entry index.
- wr_data  out  D_WIDTH  write data.
- modulus  out  D_WIDTH  latched modulus; held until the next MOD-state accept.
- busy  out  1  high in MOD, BASE and CONST.
- done  out  1  level; high in DONE.
- err  out  1  level; high in ERR.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including modulus; all counters 0.
- States and transitions:
  - IDLE --start--> MOD.
  - MOD --accept--> BASE.
  - BASE --last base accept--> CONST.
  - CONST --last const accept--> DONE.
  - DONE or ERR --start--> MOD.
- Accept condition: in_valid && in_ready. in_ready = busy, combinational from state only, never from in_valid. No skid buffer is needed.
- MOD: an accepted word is stored into modulus. If it equals 0 → ERR; otherwise → BASE. No write strobe is issued in MOD.
- BASE: counters depth (0..IT_DEPTH+2) and bank (0..TF_BANK-1).
  - Each accept issues one write, registered: the cycle after accept has wr_en=1, wr_sel=0, wr_depth/wr_bank = the counter values at accept, wr_data = the accepted word.
  - bank increments on each accept; at TF_BANK-1 it wraps to 0 and depth increments.
  - Accept at (IT_DEPTH+2, TF_BANK-1) → CONST with counters cleared.
- CONST: idx 0..TF_CONST_BANK-1. Each accept writes wr_sel=1, wr_depth=0, wr_bank=idx, one-cycle latency. Last index → DONE.
- Range check in BASE and CONST: if word >= modulus (unsigned D_WIDTH compare), no write is issued and the state goes to ERR the next cycle. Counters freeze; in_ready drops the cycle ERR is entered.
- wr_en is high exactly one cycle per valid accepted table word. Between accepts, wr_en=0 and the wr_* outputs hold their last values.
- Stalls: in_valid low for any number of cycles → no state change, no write.
- start while busy is ignored (no restart mid-load).
- Reset mid-load: immediate return to IDLE; the partial table is left in the bank, and done/err stay 0 until a new load completes.
- Totals for defaults: 1 + 90 + 15 = 106 accepted words. Minimum load time is 106 cycles after MOD entry; the final write appears 1 cycle later, coincident with done rising.

Test Plan:
- Full load, defaults, in_valid always 1: start, then modulus 97, base words k mod 97, const words 50+j.
  - Expect 105 wr_en pulses in order: (d0,b0) … (d5,b14), then const 0..14.
  - First write cycle: wr_data=0, wr_depth=0, wr_bank=0. Base write #16 has depth=1, bank=0.
  - done rises together with the last const write; modulus=97.
- Back-pressure-free stall: deassert in_valid for 5 cycles after base word 20.
  - Expect no wr_en during the gap; the next write has depth=1, bank=5. Total writes still 105.
- Range error: modulus 97, base word 3 = 97.
  - Expect writes for words 0–2 only; err=1 the next cycle; in_ready=0; done=0.
  - A subsequent start reloads cleanly to done.
- Zero modulus: start, then word 0 → err=1, no wr_en ever pulses.
- Reset mid-operation: rst_n low during CONST idx 7.
  - Expect all outputs 0 asynchronously (before the next clock edge); after release, state IDLE, in_ready=0.
  - start during a later load's BASE phase changes nothing.

Source files
------------

// File: rtl/tf_loader_if.sv
// Twiddle-factor loader bus: host stream in, bank write port and status out.
// The master side is the host/DMA; the slave side is the loader itself.
interface tf_loader_if #(
  parameter int D_WIDTH = 64
);
  logic               start;
  logic               in_valid;
  logic [D_WIDTH-1:0] in_data;
  logic               in_ready;
  logic               wr_en;
  logic               wr_sel;
  logic [2:0]         wr_depth;
  logic [3:0]         wr_bank;
  logic [D_WIDTH-1:0] wr_data;
  logic [D_WIDTH-1:0] modulus;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_sel,
    input  wr_depth, wr_bank, wr_data,
    input  modulus, busy, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_sel,
    output wr_depth, wr_bank, wr_data,
    output modulus, busy, done, err
  );
endinterface

// File: rtl/tf_loader.sv
// Twiddle-factor table loader: modulus, base rows, then constants,
// streamed into the base/constant register bank through one write port.
module tf_loader #(
  parameter int D_WIDTH       = 64,
  parameter int IT_DEPTH      = 3,
  parameter int TF_BANK       = 15,
  parameter int TF_CONST_BANK = 15
) (
  input logic       clk,
  input logic       rst_n,
  tf_loader_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_MOD,
    S_BASE,
    S_CONST,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [2:0] LAST_D = 3'(IT_DEPTH + 2);
  localparam logic [3:0] LAST_B = 4'(TF_BANK - 1);
  localparam logic [3:0] LAST_C = 4'(TF_CONST_BANK - 1);

  state_t             r_state;
  logic [2:0]         r_depth;
  logic [3:0]         r_bank;
  logic [D_WIDTH-1:0] r_mod;
  logic               r_wr_en;
  logic               r_wr_sel;
  logic [2:0]         r_wr_depth;
  logic [3:0]         r_wr_bank;
  logic [D_WIDTH-1:0] r_wr_data;

  logic w_busy;
  logic w_acc;
  logic w_in_range;

  assign w_busy = (r_state == S_MOD) ||
                  (r_state == S_BASE) ||
                  (r_state == S_CONST);
  assign w_acc = bus.in_valid && w_busy;
  assign w_in_range = bus.in_data < r_mod;

  // r_bank doubles as the constant index once the base rows are done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_depth    <= '0;
      r_bank     <= '0;
      r_mod      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_depth <= '0;
      r_wr_bank  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_state <= S_MOD;
            r_depth <= '0;
            r_bank  <= '0;
          end
        end
        S_MOD: begin
          if (w_acc) begin
            r_mod   <= bus.in_data;
            r_state <= (bus.in_data == '0) ? S_ERR : S_BASE;
          end
        end
        S_BASE: begin
          if (w_acc) begin
            if (!w_in_range) begin
              r_state <= S_ERR;
            end else begin
              r_wr_en    <= 1'b1;
              r_wr_sel   <= 1'b0;
              r_wr_depth <= r_depth;
              r_wr_bank  <= r_bank;
              r_wr_data  <= bus.in_data;
              if (r_bank == LAST_B) begin
                r_bank <= '0;
                if (r_depth == LAST_D) begin
                  r_depth <= '0;
                  r_state <= S_CONST;
                end else begin
                  r_depth <= r_depth + 3'd1;
                end
              end else begin
                r_bank <= r_bank + 4'd1;
              end
            end
          end
        end
        S_CONST: begin
          if (w_acc) begin
            if (!w_in_range) begin
              r_state <= S_ERR;
            end else begin
              r_wr_en    <= 1'b1;
              r_wr_sel   <= 1'b1;
              r_wr_depth <= '0;
              r_wr_bank  <= r_bank;
              r_wr_data  <= bus.in_data;
              if (r_bank == LAST_C) begin
                r_bank  <= '0;
                r_state <= S_DONE;
              end else begin
                r_bank <= r_bank + 4'd1;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready = w_busy;
  assign bus.busy     = w_busy;
  assign bus.done     = (r_state == S_DONE);
  assign bus.err      = (r_state == S_ERR);
  assign bus.modulus  = r_mod;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_sel   = r_wr_sel;
  assign bus.wr_depth = r_wr_depth;
  assign bus.wr_bank  = r_wr_bank;
  assign bus.wr_data  = r_wr_data;
endmodule

// File: tb/tb_tf_loader.sv
// Scoreboarded bench for tf_loader: expected bank writes are queued by
// the driver and matched by a monitor whenever wr_en is seen.
module tb_tf_loader;
  typedef struct packed {
    logic        sel;
    logic [2:0]  d;
    logic [3:0]  b;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_wr = 0;
  wr_t  q[$];
  wr_t  mon_got;
  wr_t  mon_exp;

  tf_loader_if #(.D_WIDTH(64)) bus ();

  tf_loader #(
    .D_WIDTH(64),
    .IT_DEPTH(3),
    .TF_BANK(15),
    .TF_CONST_BANK(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.wr_en) begin
      n_wr++;
      checks++;
      mon_got = '{bus.wr_sel, bus.wr_depth, bus.wr_bank, bus.wr_data};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got=%0h exp=none", mon_got);
      end else begin
        mon_exp = q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL wr got=%0h exp=%0h", mon_got, mon_exp);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [63:0] w);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic full_load(input bit stall, input bit poke);
    int w0;
    int k;
    w0 = n_wr;
    pulse_start();
    send(64'd97);
    for (int d = 0; d < 6; d++) begin
      for (int b = 0; b < 15; b++) begin
        k = d * 15 + b;
        q.push_back('{1'b0, 3'(d), 4'(b), 64'(k % 97)});
        if (poke && k == 10) bus.start = 1'b1;
        send(64'(k % 97));
        bus.start = 1'b0;
        if (stall && k == 19) begin
          bus.in_valid = 1'b0;
          repeat (5) @(negedge clk);
          chk("stall_busy", 64'(bus.busy), 64'd1);
        end
      end
    end
    for (int j = 0; j < 15; j++) begin
      q.push_back('{1'b1, 3'd0, 4'(j), 64'(50 + j)});
      send(64'(50 + j));
    end
    chk("done", 64'(bus.done), 64'd1);
    chk("done_err", 64'(bus.err), 64'd0);
    chk("done_ready", 64'(bus.in_ready), 64'd0);
    chk("modulus", bus.modulus, 64'd97);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("n_writes", 64'(n_wr - w0), 64'd105);
  endtask

  initial begin
    int w0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #3;
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
    chk("rst_mod", bus.modulus, 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    full_load(1'b0, 1'b0);
    full_load(1'b1, 1'b0);

    // range error on base word 3
    w0 = n_wr;
    pulse_start();
    send(64'd97);
    for (int k = 0; k < 3; k++) begin
      q.push_back('{1'b0, 3'd0, 4'(k), 64'(k)});
      send(64'(k));
    end
    send(64'd97);
    chk("rng_err", 64'(bus.err), 64'd1);
    chk("rng_ready", 64'(bus.in_ready), 64'd0);
    chk("rng_done", 64'(bus.done), 64'd0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rng_writes", 64'(n_wr - w0), 64'd3);
    full_load(1'b0, 1'b0);

    // zero modulus
    w0 = n_wr;
    pulse_start();
    send(64'd0);
    chk("zero_err", 64'(bus.err), 64'd1);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("zero_writes", 64'(n_wr - w0), 64'd0);

    // reset during CONST index 7
    pulse_start();
    send(64'd97);
    for (int k = 0; k < 90; k++) begin
      q.push_back('{1'b0, 3'(k / 15), 4'(k % 15), 64'(k)});
      send(64'(k));
    end
    for (int j = 0; j < 7; j++) begin
      q.push_back('{1'b1, 3'd0, 4'(j), 64'(50 + j)});
      send(64'(50 + j));
    end
    bus.in_data = 64'd57;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_wr_en", 64'(bus.wr_en), 64'd0);
    chk("ar_wr_sel", 64'(bus.wr_sel), 64'd0);
    chk("ar_wr_bank", 64'(bus.wr_bank), 64'd0);
    chk("ar_wr_data", bus.wr_data, 64'd0);
    chk("ar_mod", bus.modulus, 64'd0);
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_ready", 64'(bus.in_ready), 64'd0);
    chk("post_done", 64'(bus.done), 64'd0);
    chk("post_err", 64'(bus.err), 64'd0);
    chk("sb_after_rst", 64'(q.size()), 64'd0);

    full_load(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
